// File: rtl/vga_pkg.sv
// Shared 800x600@60 raster constants for the timing generator and the draw stages.
package vga_pkg;
  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FRONT  = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BACK   = 88;
  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FRONT  = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BACK   = 23;
  localparam bit VGA_SYNC_POL = 1'b1;
  localparam int VGA_CW       = 11;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FRONT;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FRONT;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;
endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: generator drives (master), draw/sync stages consume (slave).
interface vga_timing_if #(parameter int CW = vga_pkg::VGA_CW);
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          hblnk;
  logic          vblnk;
  logic          frame_tick;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_tick);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_tick);
endinterface

// File: rtl/vga_timing.sv
// Free-running raster counter pair; every output is registered from the next-state
// counts so flags line up with the counts shown in the same cycle.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK,
  parameter bit SYNC_POL = VGA_SYNC_POL,
  parameter int CW       = VGA_CW
) (
  input  logic         pclk,
  input  logic         rst,
  vga_timing_if.master vga
);
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

  if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_porch
    $error("vga_timing: porch and sync widths must be >= 1");
  end
  if ((64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_bad_cw
    $error("vga_timing: CW too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CW-1:0] r_hcount, r_vcount;
  logic          r_hsync, r_vsync, r_hblnk, r_vblnk, r_frame_tick;
  logic [CW-1:0] w_hnext, w_vnext;
  logic          w_hwrap, w_vwrap, w_hs_act, w_vs_act;

  always_comb begin
    w_hwrap  = (r_hcount == H_LAST);
    w_vwrap  = (r_vcount == V_LAST);
    w_hnext  = w_hwrap ? '0 : r_hcount + 1'b1;
    w_vnext  = r_vcount;
    if (w_hwrap) w_vnext = w_vwrap ? '0 : r_vcount + 1'b1;
    w_hs_act = (w_hnext >= HS_START) && (w_hnext < HS_END);
    w_vs_act = (w_vnext >= VS_START) && (w_vnext < VS_END);
  end

  // XOR with ~SYNC_POL turns "pulse active" into the pin level for either polarity.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_hcount     <= '0;
      r_vcount     <= '0;
      r_hblnk      <= 1'b0;
      r_vblnk      <= 1'b0;
      r_frame_tick <= 1'b0;
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
    end else begin
      r_hcount     <= w_hnext;
      r_vcount     <= w_vnext;
      r_hblnk      <= (w_hnext >= H_ACT);
      r_vblnk      <= (w_vnext >= V_ACT);
      r_frame_tick <= w_hwrap && w_vwrap;
      r_hsync      <= w_hs_act ^ ~SYNC_POL;
      r_vsync      <= w_vs_act ^ ~SYNC_POL;
    end
  end

  assign vga.hcount     = r_hcount;
  assign vga.vcount     = r_vcount;
  assign vga.hsync      = r_hsync;
  assign vga.vsync      = r_vsync;
  assign vga.hblnk      = r_hblnk;
  assign vga.vblnk      = r_vblnk;
  assign vga.frame_tick = r_frame_tick;
endmodule
